reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Staged power-up and reset controller for the ToF driver.
- Releases up to `stages` downstream reset domains one at a time, in fixed order (e.g. PLL, sensor analog, sensor digital, readout).
- Before releasing the next domain, each stage waits for its `ready` indication plus a settle gap.
- Stage timeouts and external faults cause a full re-sequence with a bounded retry count. An unrecoverable fault latches an error.

Parameters:
stages, 3, number of sequenced reset domains (1..8)
ticks, 1000, clk cycles of initial hold and of the settle gap between stages
timeout, 65535, clk cycles allowed for `ready[k]` after `rst_out[k]` deasserts
retries, 3, number of re-sequences allowed before entering ERROR

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
ready  input  stages  per-stage ready/lock; asynchronous to clk
fault  input  1  synchronous pulse requesting a full re-sequence
rst_out  output  stages  per-domain reset, active-high, registered
done  output  1  all domains released and all ready
error  output  1  retries exhausted; latched until rst
stage  output  3  index of the stage currently waited on (0 in HOLD/RUN/ERROR)

Behaviour:
- Reset: `rst` is asynchronous, active-high. While it is high: `rst_out` all ones, `done`=0, `error`=0, `stage`=0, state=HOLD, cnt=0, retry count=0. These take effect immediately, without a clock edge.
- `ready` synchronisation: each bit passes through a 2-flop synchroniser, giving `ready_s` with 2-cycle latency. `ready` is used only through `ready_s`.
- Counter:
  - Single cnt, width clogb2(max(ticks, timeout)).
  - Loaded with 0 on every state entry.
  - Increments once per clk in HOLD, GAP and WAIT.
- HOLD: all `rst_out`=1. When cnt==ticks-1: clear `rst_out[0]`, go to WAIT(0).
- WAIT(k):
  - If `ready_s[k]`=1: go to GAP(k), or to RUN if k==stages-1.
  - Else if cnt==timeout-1: take the restart path.
  - If `ready_s` and the timeout occur in the same cycle, `ready_s` wins.
- GAP(k): when cnt==ticks-1, clear `rst_out[k+1]` and go to WAIT(k+1).
- Cleared `rst_out` bits stay cleared until a restart. Release order is strictly monotonic.
- RUN:
  - `done`=1, `rst_out` all zero.
  - The retry count is cleared on entry to RUN.
- Restart path:
  - Triggers: WAIT timeout, or any already-released stage j with `ready_s[j]` falling during WAIT or GAP.
  - On the next edge: `rst_out` all ones, `done`=0.
  - If retry count==retries: go to ERROR. Otherwise increment the retry count and go to HOLD with cnt=0.
- `fault`:
  - In RUN, WAIT or GAP: `rst_out` all ones on the next edge and go to HOLD. The retry count is not incremented.
  - In HOLD: cnt reloads to 0.
  - In ERROR: ignored.
- RUN ready loss: a drop of any `ready_s` bit in RUN is treated like `fault`.
- ERROR: `rst_out` all ones, `error`=1, `done`=0. Exit only via `rst`.
- Output registration: all outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- clogb2 comes from the shared auxiliary-functions include.
- State encodings (HOLD, WAIT, GAP, RUN, ERROR) are localparams in the module. No package is needed.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with asynchronous reset to 0, instantiated once per `ready` bit.

Test Plan:
All scenarios use stages=3, ticks=8, timeout=20, retries=2. Edge numbers are counted from the first clk edge after `rst` falls.
1. `ready` tied to 3'b111 → `rst_out`=111 through edge 7; 110 at edge 8; 100 at edge 17; 000 at edge 26; `done`=1 from edge 27.
2. `ready[1]` stuck at 0, others 1 → sequence times out in WAIT(1) three times; after the third timeout `error`=1, `rst_out`=111, `done`=0. Both stay so across a later `fault` pulse.
3. Reach RUN, then pulse `fault` for 1 cycle → `rst_out`=111 and `done`=0 on the next edge; full re-sequence completes with identical spacing; `error` never asserts even after 5 repeated faults.
4. Drop `ready[0]` for 4 cycles during GAP(1) → restart with `rst_out`=111. With retry count 1, recovery to RUN after `ready[0]` returns.
5. Assert `rst` asynchronously mid-GAP(1), between clk edges → `rst_out`=111, `done`=0, `error`=0, `stage`=0 before the next clk edge; sequencing restarts from HOLD.
6. `ready[2]` rises in the same cycle cnt reaches timeout-1 in WAIT(2) → enter RUN, no retry consumed.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared helpers for the reset sequencer: ceiling-log2 width calculation.
package reset_sequencer_pkg;

    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned width;
        width = 32'd1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for a signal asynchronous to clk.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture; both flops clear on reset so ready reads low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: HOLD, then WAIT/GAP per domain, RUN when all are ready.
// Timeouts and ready loss re-sequence with a bounded retry budget, then ERROR.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int stages  = 3,
    parameter int ticks   = 1000,
    parameter int timeout = 65535,
    parameter int retries = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [stages-1:0] ready,
    input  logic              fault,
    output logic [stages-1:0] rst_out,
    output logic              done,
    output logic              error,
    output logic [2:0]        stage
);

    localparam int cnt_w   = clogb2((ticks > timeout) ? ticks : timeout);
    localparam int retry_w = clogb2(retries + 1);

    localparam logic [2:0] ST_HOLD  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [cnt_w-1:0]   cnt_zero   = cnt_w'(32'd0);
    localparam logic [cnt_w-1:0]   cnt_one    = cnt_w'(32'd1);
    localparam logic [cnt_w-1:0]   ticks_m1   = cnt_w'(ticks - 1);
    localparam logic [cnt_w-1:0]   timeout_m1 = cnt_w'(timeout - 1);
    localparam logic [retry_w-1:0] retry_zero = retry_w'(32'd0);
    localparam logic [retry_w-1:0] retry_one  = retry_w'(32'd1);
    localparam logic [retry_w-1:0] retry_max  = retry_w'(retries);
    localparam logic [2:0]         last_k     = 3'(stages - 1);
    localparam logic [stages-1:0]  one_lsb    = stages'(32'd1);
    localparam logic [stages-1:0]  all_ones   = {stages{1'b1}};
    localparam logic [stages-1:0]  all_zeros  = stages'(32'd0);

    logic [stages-1:0]  ready_s;
    logic [2:0]         state_r, state_s;
    logic [2:0]         k_r, k_s;
    logic [cnt_w-1:0]   cnt_r, cnt_s;
    logic [retry_w-1:0] retry_r, retry_s;
    logic [stages-1:0]  cur_bit_s, below_s, nxt_bit_s;
    logic               lost_wait_s, lost_gap_s, advance_s;
    logic               requeue_s, restart_s;
    logic [stages-1:0]  rst_out_s;
    logic [2:0]         stage_s;

    for (genvar i = 0; i < stages; i++) begin : g_sync
        sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d   (ready[i]),
            .q   (ready_s[i])
        );
    end

    // Next-state logic; fault outranks ready loss, which outranks advancing.
    always_comb begin
        cur_bit_s   = one_lsb << k_r;
        below_s     = cur_bit_s - one_lsb;
        lost_wait_s = |(below_s & ~ready_s);
        lost_gap_s  = |((below_s | cur_bit_s) & ~ready_s);
        advance_s   = |(cur_bit_s & ready_s);
        state_s     = state_r;
        k_s         = k_r;
        cnt_s       = cnt_r + cnt_one;
        retry_s     = retry_r;
        requeue_s   = 1'b0;
        restart_s   = 1'b0;
        case (state_r)
            ST_HOLD: begin
                if (fault) begin
                    cnt_s = cnt_zero;
                end else if (cnt_r == ticks_m1) begin
                    state_s = ST_WAIT;
                    k_s     = 3'd0;
                    cnt_s   = cnt_zero;
                end else begin
                    cnt_s = cnt_r + cnt_one;
                end
            end
            ST_WAIT: begin
                if (fault) begin
                    requeue_s = 1'b1;
                end else if (lost_wait_s) begin
                    restart_s = 1'b1;
                end else if (advance_s) begin
                    cnt_s = cnt_zero;
                    if (k_r == last_k) begin
                        state_s = ST_RUN;
                        retry_s = retry_zero;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else if (cnt_r == timeout_m1) begin
                    restart_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + cnt_one;
                end
            end
            ST_GAP: begin
                if (fault) begin
                    requeue_s = 1'b1;
                end else if (lost_gap_s) begin
                    restart_s = 1'b1;
                end else if (cnt_r == ticks_m1) begin
                    state_s = ST_WAIT;
                    k_s     = k_r + 3'd1;
                    cnt_s   = cnt_zero;
                end else begin
                    cnt_s = cnt_r + cnt_one;
                end
            end
            ST_RUN: begin
                cnt_s = cnt_zero;
                if (fault || (ready_s != all_ones)) begin
                    requeue_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ERROR: begin
                cnt_s   = cnt_zero;
                state_s = ST_ERROR;
            end
            default: begin
                state_s = ST_HOLD;
                k_s     = 3'd0;
                cnt_s   = cnt_zero;
            end
        endcase
        case ({requeue_s, restart_s})
            2'b10, 2'b11: begin
                state_s = ST_HOLD;
                k_s     = 3'd0;
                cnt_s   = cnt_zero;
            end
            2'b01: begin
                if (retry_r == retry_max) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_HOLD;
                    retry_s = retry_r + retry_one;
                end
                k_s   = 3'd0;
                cnt_s = cnt_zero;
            end
            default: begin
                k_s = k_s;
            end
        endcase
    end

    // Output values for the state being entered, so the outputs leave flops.
    always_comb begin
        nxt_bit_s = one_lsb << k_s;
        rst_out_s = all_ones;
        stage_s   = 3'd0;
        case (state_s)
            ST_WAIT, ST_GAP: begin
                rst_out_s = ~((nxt_bit_s - one_lsb) | nxt_bit_s);
                stage_s   = k_s;
            end
            ST_RUN: begin
                rst_out_s = all_zeros;
                stage_s   = 3'd0;
            end
            default: begin
                rst_out_s = all_ones;
                stage_s   = 3'd0;
            end
        endcase
    end

    // State, counter, retry count and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HOLD;
            k_r     <= 3'd0;
            cnt_r   <= cnt_zero;
            retry_r <= retry_zero;
            rst_out <= all_ones;
            done    <= 1'b0;
            error   <= 1'b0;
            stage   <= 3'd0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            cnt_r   <= cnt_s;
            retry_r <= retry_s;
            rst_out <= rst_out_s;
            done    <= (state_s == ST_RUN);
            error   <= (state_s == ST_ERROR);
            stage   <= stage_s;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table, corner sequences and
// randomized traffic compared every cycle against a behavioural model.
module tb_reset_sequencer;

    localparam int S  = 3;
    localparam int T  = 8;
    localparam int TO = 20;
    localparam int R  = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [2:0] ready = 3'b111;
    logic       fault = 1'b0;
    logic [2:0] rst_out;
    logic       done;
    logic       error;
    logic [2:0] stage;

    reset_sequencer #(.stages(S), .ticks(T), .timeout(TO), .retries(R)) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .fault   (fault),
        .rst_out (rst_out),
        .done    (done),
        .error   (error),
        .stage   (stage)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int edge_n = 0;

    typedef enum int {M_HOLD, M_WAIT, M_GAP, M_RUN, M_ERR} mode_t;
    mode_t      m_mode  = M_HOLD;
    int         m_k     = 0;
    int         m_cnt   = 0;
    int         m_retry = 0;
    logic [2:0] m_s1    = 3'b000;
    logic [2:0] m_s2    = 3'b000;

    typedef struct {
        int         edges;
        logic [2:0] rdy;
        logic       flt;
        logic [2:0] exp_rst;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    task automatic model_reset();
        m_mode = M_HOLD; m_k = 0; m_cnt = 0; m_retry = 0;
        m_s1 = 3'b000; m_s2 = 3'b000;
    endtask

    function automatic bit any_low(logic [2:0] rs, int n);
        logic [3:0] mask;
        mask = (4'd1 << n) - 4'd1;
        return ((rs | ~mask[2:0]) != 3'b111);
    endfunction

    task automatic m_restart();
        if (m_retry == R) m_mode = M_ERR;
        else begin m_retry++; m_mode = M_HOLD; end
        m_cnt = 0;
    endtask

    task automatic m_requeue();
        m_mode = M_HOLD; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [2:0] rs;
        rs = m_s2;
        case (m_mode)
            M_HOLD: begin
                if (fault) m_cnt = 0;
                else if (m_cnt == T - 1) begin m_mode = M_WAIT; m_k = 0; m_cnt = 0; end
                else m_cnt++;
            end
            M_WAIT: begin
                if (fault) m_requeue();
                else if (any_low(rs, m_k)) m_restart();
                else if (rs[m_k[1:0]]) begin
                    if (m_k == S - 1) begin m_mode = M_RUN; m_retry = 0; end
                    else begin m_mode = M_GAP; m_cnt = 0; end
                end
                else if (m_cnt == TO - 1) m_restart();
                else m_cnt++;
            end
            M_GAP: begin
                if (fault) m_requeue();
                else if (any_low(rs, m_k + 1)) m_restart();
                else if (m_cnt == T - 1) begin m_mode = M_WAIT; m_k++; m_cnt = 0; end
                else m_cnt++;
            end
            M_RUN: begin
                if (fault || rs != 3'b111) m_requeue();
            end
            default: begin
            end
        endcase
        m_s2 = m_s1;
        m_s1 = ready;
    endtask

    // Expected {rst_out, done, error, stage}: released domains form a prefix.
    function automatic logic [8:0] model_out();
        int         rel;
        logic [3:0] rel_mask;
        logic [2:0] st;
        rel = 0;
        st  = 3'd0;
        if (m_mode == M_WAIT || m_mode == M_GAP) begin rel = m_k + 1; st = 3'(m_k); end
        else if (m_mode == M_RUN) rel = S;
        rel_mask = (4'd1 << rel) - 4'd1;
        return {~rel_mask[2:0], m_mode == M_RUN, m_mode == M_ERR, st};
    endfunction

    task automatic tick();
        logic [8:0] want;
        @(posedge clk);
        edge_n++;
        if (rst) model_reset();
        else model_step();
        #1;
        want = model_out();
        total++;
        if ({rst_out, done, error, stage} !== want) begin
            bad++;
            $display("FAIL model edge=%0d got rst_out/done/error/stage=%b required %b",
                     edge_n, {rst_out, done, error, stage}, want);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic do_reset(input logic [2:0] rdy);
        rst = 1'b1; fault = 1'b0; ready = rdy;
        tick();
        tick();
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic run_until_done(input int budget, output int used);
        used = 0;
        while (done !== 1'b1 && used < budget) begin
            tick();
            used++;
        end
    endtask

    initial begin
        vec_t       vecs[$];
        int         used;
        int         err_run;
        logic [2:0] r;

        vecs.push_back('{7, 3'b111, 1'b0, 3'b111, 1'b0, 1'b0});
        vecs.push_back('{1, 3'b111, 1'b0, 3'b110, 1'b0, 1'b0});
        vecs.push_back('{8, 3'b111, 1'b0, 3'b110, 1'b0, 1'b0});
        vecs.push_back('{1, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0});
        vecs.push_back('{8, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0});
        vecs.push_back('{1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{1, 3'b111, 1'b0, 3'b000, 1'b1, 1'b0});
        vecs.push_back('{5, 3'b111, 1'b0, 3'b000, 1'b1, 1'b0});
        vecs.push_back('{1, 3'b111, 1'b1, 3'b111, 1'b0, 1'b0});
        vecs.push_back('{7, 3'b111, 1'b0, 3'b111, 1'b0, 1'b0});
        vecs.push_back('{1, 3'b111, 1'b0, 3'b110, 1'b0, 1'b0});

        #2 rst = 1'b1;
        do_reset(3'b111);
        check("reset_rst_out", int'(rst_out), 7);
        foreach (vecs[i]) begin
            ready = vecs[i].rdy;
            fault = vecs[i].flt;
            repeat (vecs[i].edges) tick();
            fault = 1'b0;
            check($sformatf("vec%0d_rst_out", i), int'(rst_out), int'(vecs[i].exp_rst));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
            check($sformatf("vec%0d_error", i), int'(error), int'(vecs[i].exp_err));
        end

        // ready[1] stuck low: three timeouts exhaust the retries
        do_reset(3'b101);
        used = 0;
        while (error !== 1'b1 && used < 300) begin tick(); used++; end
        check("stuck_error", int'(error), 1);
        check("stuck_error_edge", edge_n, 111);
        fault = 1'b1; tick(); fault = 1'b0;
        repeat (5) tick();
        check("stuck_error_held", int'(error), 1);
        check("stuck_rst_out", int'(rst_out), 7);
        check("stuck_done", int'(done), 0);

        // repeated faults from RUN re-sequence with identical spacing
        do_reset(3'b111);
        run_until_done(60, used);
        check("fault_first_run", used, 27);
        for (int n = 0; n < 5; n++) begin
            fault = 1'b1; tick(); fault = 1'b0;
            check("fault_rst_out", int'(rst_out), 7);
            check("fault_done", int'(done), 0);
            run_until_done(60, used);
            check("fault_respacing", used, 27);
            check("fault_no_error", int'(error), 0);
        end

        // ready[0] lost during GAP(1)
        do_reset(3'b111);
        repeat (20) tick();
        check("gap1_stage", int'(stage), 1);
        ready = 3'b110;
        repeat (4) tick();
        ready = 3'b111;
        check("loss_rst_out", int'(rst_out), 7);
        check("loss_done", int'(done), 0);
        run_until_done(80, used);
        check("loss_recovered", int'(done), 1);
        check("loss_recover_edge", edge_n, 50);
        check("loss_no_error", int'(error), 0);

        // asynchronous reset between edges in GAP(1)
        do_reset(3'b111);
        repeat (20) tick();
        check("async_pre_rst_out", int'(rst_out), 4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_out", int'(rst_out), 7);
        check("async_done", int'(done), 0);
        check("async_error", int'(error), 0);
        check("async_stage", int'(stage), 0);
        tick();
        rst = 1'b0;
        edge_n = 0;
        run_until_done(60, used);
        check("async_resequence", used, 27);

        // ready[2] arrives exactly on the last timeout cycle of WAIT(2)
        do_reset(3'b011);
        repeat (43) tick();
        ready = 3'b111;
        repeat (2) tick();
        check("race_done_before", int'(done), 0);
        tick();
        check("race_done", int'(done), 1);
        check("race_rst_out", int'(rst_out), 0);

        // one cycle later the timeout wins
        do_reset(3'b011);
        repeat (44) tick();
        ready = 3'b111;
        repeat (2) tick();
        check("late_rst_out", int'(rst_out), 7);
        check("late_done", int'(done), 0);

        // randomized ready drops and faults
        do_reset(3'b111);
        err_run = 0;
        for (int n = 0; n < 4000; n++) begin
            r = ready;
            for (int b = 0; b < 3; b++) begin
                if (r[b[1:0]]) begin
                    if ($urandom_range(0, 199) == 0) r[b[1:0]] = 1'b0;
                end else begin
                    if ($urandom_range(0, 9) == 0) r[b[1:0]] = 1'b1;
                end
            end
            ready = r;
            fault = ($urandom_range(0, 299) == 0);
            tick();
            if (error) err_run++;
            else err_run = 0;
            if (err_run > 10) begin
                do_reset(r);
                err_run = 0;
            end
        end
        fault = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
